// File: rtl/cnn1d_pkg.sv
// Shared types and sizing for the 1-D CNN job sequencer and its result FIFO.
package cnn1d_pkg;

  localparam int unsigned NUM_PSUM   = 15;
  localparam int unsigned TAPS       = 3;
  localparam int unsigned NUM_RES    = NUM_PSUM / TAPS;
  localparam int unsigned DW         = 4;
  localparam int unsigned RW         = 10;
  localparam int unsigned FIFO_DEPTH = 4;

  localparam int unsigned WR_CNT_W   = $clog2(NUM_PSUM + 1);
  localparam int unsigned IDX_W      = 3;
  localparam int unsigned FIFO_CNT_W = $clog2(FIFO_DEPTH + 1);
  localparam int unsigned ENTRY_W    = IDX_W + RW;

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOAD,
    S_READ,
    S_FINISH
  } state_t;

  typedef struct packed {
    logic [IDX_W-1:0] index;
    logic [RW-1:0]    data;
  } res_entry_t;

endpackage

// File: rtl/cnn1d_res_fifo.sv
// Small synchronous FIFO holding {index, data} convolution results; flush empties it.
module cnn1d_res_fifo
  import cnn1d_pkg::*;
#(
  parameter int unsigned DEPTH = FIFO_DEPTH
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       flush,
  input  logic                       push,
  input  logic [ENTRY_W-1:0]         push_data,
  input  logic                       pop,
  output logic [ENTRY_W-1:0]         head,
  output logic                       valid,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  logic [ENTRY_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]   wr_ptr;
  logic [PTR_W-1:0]   rd_ptr;
  logic               do_push;
  logic               do_pop;

  function automatic logic [PTR_W-1:0] bump(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  assign valid   = (count != '0);
  assign do_pop  = pop && valid;
  assign do_push = push && (count < CNT_W'(DEPTH));
  assign head    = mem[rd_ptr];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= bump(wr_ptr);
      end
      if (do_pop) rd_ptr <= bump(rd_ptr);
      case ({do_push, do_pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/cnn1d_job_sequencer.sv
// Sequences one convolution job: streams 15 operand pairs into the datapath,
// issues 5 credit-limited reads, and queues the results for the consumer.
module cnn1d_job_sequencer
  import cnn1d_pkg::*;
(
  input  logic          clk,
  input  logic          reset,
  input  logic          job_start,
  input  logic          abort,
  output logic          busy,
  output logic          job_done,
  input  logic          pix_valid,
  output logic          pix_ready,
  input  logic [DW-1:0] pix_image,
  input  logic [DW-1:0] pix_filter,
  output logic          dp_start,
  output logic [DW-1:0] dp_image,
  output logic [DW-1:0] dp_filter,
  output logic          dp_read_en,
  output logic          dp_reset_n,
  input  logic [RW-1:0] dp_conv_result,
  output logic          res_valid,
  input  logic          res_ready,
  output logic [RW-1:0] res_data,
  output logic [2:0]    res_index
);

  state_t                state;
  state_t                state_next;
  logic [WR_CNT_W-1:0]   wr_cnt;
  logic [IDX_W-1:0]      rd_cnt;
  logic                  v1;
  logic                  v2;
  logic [IDX_W-1:0]      idx1;
  logic [IDX_W-1:0]      idx2;
  logic                  abort_q;
  logic [FIFO_CNT_W-1:0] fifo_cnt;
  logic [FIFO_CNT_W-1:0] inflight;
  logic                  credit_ok;
  logic [ENTRY_W-1:0]    head_bits;
  res_entry_t            push_entry;
  res_entry_t            head_entry;

  // Reads still in the datapath pipe hold a FIFO slot so a stalled consumer never overflows it.
  assign inflight  = FIFO_CNT_W'(v1) + FIFO_CNT_W'(v2);
  assign credit_ok = (fifo_cnt + inflight) < FIFO_CNT_W'(FIFO_DEPTH);

  assign dp_image   = pix_image;
  assign dp_filter  = pix_filter;
  assign dp_reset_n = reset & ~abort_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= S_IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    if (abort) begin
      state_next = S_IDLE;
    end else begin
      case (state)
        S_IDLE:   if (job_start) state_next = S_LOAD;
        S_LOAD:   if (pix_valid && (wr_cnt == WR_CNT_W'(NUM_PSUM - 1))) state_next = S_READ;
        S_READ:   if ((rd_cnt == IDX_W'(NUM_RES)) && !v1 && !v2) state_next = S_FINISH;
        S_FINISH: if (fifo_cnt == '0) state_next = S_IDLE;
        default:  state_next = S_IDLE;
      endcase
    end
  end

  always_comb begin
    busy       = (state != S_IDLE);
    pix_ready  = 1'b0;
    dp_start   = 1'b0;
    dp_read_en = 1'b0;
    job_done   = 1'b0;
    case (state)
      S_LOAD: begin
        pix_ready = 1'b1;
        dp_start  = pix_valid && !abort;
      end
      S_READ:   dp_read_en = !abort && (rd_cnt < IDX_W'(NUM_RES)) && credit_ok;
      S_FINISH: job_done   = !abort && (fifo_cnt == '0);
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      abort_q <= 1'b0;
    end else begin
      abort_q <= abort;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_cnt <= '0;
      rd_cnt <= '0;
      v1     <= 1'b0;
      v2     <= 1'b0;
      idx1   <= '0;
      idx2   <= '0;
    end else if (abort) begin
      wr_cnt <= '0;
      rd_cnt <= '0;
      v1     <= 1'b0;
      v2     <= 1'b0;
    end else begin
      v1   <= dp_read_en;
      idx1 <= rd_cnt;
      v2   <= v1;
      idx2 <= idx1;
      if (state == S_IDLE && job_start) begin
        wr_cnt <= '0;
        rd_cnt <= '0;
      end else begin
        if (dp_start)   wr_cnt <= wr_cnt + WR_CNT_W'(1);
        if (dp_read_en) rd_cnt <= rd_cnt + IDX_W'(1);
      end
    end
  end

  assign push_entry.index = idx2;
  assign push_entry.data  = dp_conv_result;
  assign head_entry       = res_entry_t'(head_bits);
  assign res_data         = head_entry.data;
  assign res_index        = head_entry.index;

  cnn1d_res_fifo #(
    .DEPTH(FIFO_DEPTH)
  ) u_res_fifo (
    .clk      (clk),
    .reset    (reset),
    .flush    (abort),
    .push     (v2),
    .push_data(push_entry),
    .pop      (res_ready),
    .head     (head_bits),
    .valid    (res_valid),
    .count    (fifo_cnt)
  );

endmodule

// File: tb/tb_cnn1d_job_sequencer.sv
// Bench for cnn1d_job_sequencer with a behavioural multiplier/register-file/adder datapath.
module tb_cnn1d_job_sequencer;
  import cnn1d_pkg::*;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          job_start = 1'b0;
  logic          abort = 1'b0;
  logic          busy, job_done;
  logic          pix_valid = 1'b0;
  logic          pix_ready;
  logic [DW-1:0] pix_image = '0;
  logic [DW-1:0] pix_filter = '0;
  logic          dp_start;
  logic [DW-1:0] dp_image, dp_filter;
  logic          dp_read_en, dp_reset_n;
  logic [RW-1:0] dp_conv_result;
  logic          res_valid;
  logic          res_ready = 1'b1;
  logic [RW-1:0] res_data;
  logic [2:0]    res_index;

  always #5 clk = ~clk;

  cnn1d_job_sequencer dut (
    .clk           (clk),
    .reset         (reset),
    .job_start     (job_start),
    .abort         (abort),
    .busy          (busy),
    .job_done      (job_done),
    .pix_valid     (pix_valid),
    .pix_ready     (pix_ready),
    .pix_image     (pix_image),
    .pix_filter    (pix_filter),
    .dp_start      (dp_start),
    .dp_image      (dp_image),
    .dp_filter     (dp_filter),
    .dp_read_en    (dp_read_en),
    .dp_reset_n    (dp_reset_n),
    .dp_conv_result(dp_conv_result),
    .res_valid     (res_valid),
    .res_ready     (res_ready),
    .res_data      (res_data),
    .res_index     (res_index)
  );

  // Datapath: ring write counter over 15 words, ring read counter over 5 triples,
  // register-file read stage then adder stage (two cycles read latency).
  logic [2*DW-1:0] psum [NUM_PSUM];
  int unsigned     m_wptr = 0;
  int unsigned     m_rptr = 0;
  logic [RW-1:0]   s1a = '0, s1b = '0, s1c = '0;
  logic [RW-1:0]   m_sum = '0;
  assign dp_conv_result = m_sum;

  always @(posedge clk) begin
    if (!dp_reset_n) begin
      m_wptr <= 0;
      m_rptr <= 0;
    end else begin
      if (dp_start) begin
        psum[m_wptr] <= dp_image * dp_filter;
        m_wptr <= (m_wptr == NUM_PSUM - 1) ? 0 : m_wptr + 1;
      end
      if (dp_read_en) begin
        s1a <= RW'(psum[3*m_rptr]);
        s1b <= RW'(psum[3*m_rptr+1]);
        s1c <= RW'(psum[3*m_rptr+2]);
        m_rptr <= (m_rptr == NUM_RES - 1) ? 0 : m_rptr + 1;
      end
    end
    m_sum <= s1a + s1b + s1c;
  end

  typedef struct {
    int unsigned idx;
    int unsigned data;
  } exp_t;

  exp_t        exp_q[$];
  int unsigned n_checks = 0;
  int unsigned n_fail = 0;
  int unsigned n_start = 0, n_read = 0, n_done = 0, n_pop = 0, n_dprst = 0;
  int unsigned img_a [NUM_PSUM];
  int unsigned flt_a [NUM_PSUM];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (reset) begin
      if (dp_start)    n_start++;
      if (dp_read_en)  n_read++;
      if (job_done)    n_done++;
      if (!dp_reset_n) n_dprst++;
      if (res_valid && res_ready) begin
        n_pop++;
        if (exp_q.size() == 0) begin
          check("unexpected_result", 32'(res_data), 32'hFFFF_FFFF);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          check("res_index", 32'(res_index), e.idx);
          check("res_data", 32'(res_data), e.data);
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_operands(input int unsigned img_fixed, input int unsigned flt_fixed, input bit ramp);
    for (int unsigned i = 0; i < NUM_PSUM; i++) begin
      img_a[i] = ramp ? i : img_fixed;
      flt_a[i] = flt_fixed;
    end
  endtask

  task automatic push_expected();
    for (int unsigned k = 0; k < NUM_RES; k++) begin
      exp_t e;
      e.idx  = k;
      e.data = img_a[3*k]*flt_a[3*k] + img_a[3*k+1]*flt_a[3*k+1] + img_a[3*k+2]*flt_a[3*k+2];
      exp_q.push_back(e);
    end
  endtask

  task automatic start_job();
    job_start = 1'b1;
    step();
    job_start = 1'b0;
    check("load_pix_ready", 32'(pix_ready), 1);
  endtask

  task automatic feed(input int unsigned n, input bit gaps);
    int unsigned sent = 0;
    int unsigned cyc = 0;
    bit v;
    while (sent < n && cyc < 200) begin
      v = gaps ? (cyc % 2 == 0) : 1'b1;
      pix_valid  = v;
      pix_image  = DW'(img_a[sent]);
      pix_filter = DW'(flt_a[sent]);
      #1;
      if (!v) check("gap_dp_start", 32'(dp_start), 0);
      if (v && pix_ready) sent++;
      step();
      cyc++;
    end
    pix_valid = 1'b0;
    if (sent < n) check("feed_timeout", sent, n);
  endtask

  task automatic wait_done(input int unsigned budget);
    int unsigned d0 = n_done;
    int unsigned i = 0;
    while (n_done == d0 && i < budget) begin
      @(negedge clk);
      i++;
    end
    check("job_done_seen", n_done - d0, 1);
    step();
  endtask

  task automatic run_job(input bit gaps);
    int unsigned s0 = n_start, r0 = n_read, p0 = n_pop, d0 = n_done;
    start_job();
    feed(NUM_PSUM, gaps);
    push_expected();
    wait_done(200);
    repeat (3) step();
    check("dp_start_cycles", n_start - s0, NUM_PSUM);
    check("read_en_cycles", n_read - r0, NUM_RES);
    check("results_popped", n_pop - p0, NUM_RES);
    check("job_done_once", n_done - d0, 1);
    check("scoreboard_empty", exp_q.size(), 0);
    check("idle_after_job", 32'(busy), 0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got time limit expected end of test");
    $fatal(1);
  end

  initial begin
    int unsigned s0, r0, p0, d0, rst0;

    // Reset state
    repeat (2) step();
    check("rst_busy", 32'(busy), 0);
    check("rst_job_done", 32'(job_done), 0);
    check("rst_pix_ready", 32'(pix_ready), 0);
    check("rst_dp_start", 32'(dp_start), 0);
    check("rst_dp_read_en", 32'(dp_read_en), 0);
    check("rst_res_valid", 32'(res_valid), 0);
    check("rst_res_data", 32'(res_data), 0);
    check("rst_res_index", 32'(res_index), 0);
    check("rst_dp_reset_n", 32'(dp_reset_n), 0);
    reset = 1'b1;
    step();
    check("dp_reset_n_released", 32'(dp_reset_n), 1);

    // Nominal: image=i, filter=1 -> 3,12,21,30,39
    set_operands(0, 1, 1'b1);
    run_job(1'b0);

    // Input gaps: 15x15 everywhere -> 675
    set_operands(15, 15, 1'b0);
    run_job(1'b1);

    // Backpressure: only four reads may be outstanding while consumer stalls
    set_operands(0, 1, 1'b1);
    res_ready = 1'b0;
    s0 = n_start; r0 = n_read; p0 = n_pop;
    start_job();
    feed(NUM_PSUM, 1'b0);
    push_expected();
    repeat (20) step();
    check("bp_read_en_stalled", n_read - r0, FIFO_DEPTH);
    check("bp_res_valid", 32'(res_valid), 1);
    check("bp_busy", 32'(busy), 1);
    check("bp_no_pops", n_pop - p0, 0);
    res_ready = 1'b1;
    wait_done(200);
    check("bp_read_en_total", n_read - r0, NUM_RES);
    check("bp_results", n_pop - p0, NUM_RES);
    check("bp_scoreboard_empty", exp_q.size(), 0);

    // Abort after 7 pairs
    set_operands(0, 1, 1'b1);
    d0 = n_done; rst0 = n_dprst;
    start_job();
    feed(7, 1'b0);
    abort = 1'b1;
    step();
    abort = 1'b0;
    check("abort_idle", 32'(busy), 0);
    check("abort_dp_reset_low", 32'(dp_reset_n), 0);
    step();
    check("abort_dp_reset_high", 32'(dp_reset_n), 1);
    check("abort_dp_reset_cycles", n_dprst - rst0, 1);
    check("abort_no_job_done", n_done - d0, 0);

    // Abort beats job_start; abort in IDLE still pulses datapath reset
    job_start = 1'b1;
    abort = 1'b1;
    step();
    job_start = 1'b0;
    abort = 1'b0;
    check("abort_wins_idle", 32'(busy), 0);
    check("abort_idle_dp_reset", 32'(dp_reset_n), 0);
    step();

    // Job after abort must see re-homed datapath counters
    run_job(1'b0);

    // Back-to-back without datapath reset, filter=2 -> 6,24,42,60,78
    rst0 = n_dprst;
    set_operands(0, 2, 1'b1);
    s0 = n_start;
    start_job();
    job_start = 1'b1;
    step();
    job_start = 1'b0;
    check("start_while_busy", 32'(busy), 1);
    feed(NUM_PSUM, 1'b0);
    push_expected();
    wait_done(200);
    check("b2b_dp_start_cycles", n_start - s0, NUM_PSUM);
    check("b2b_no_dp_reset", n_dprst - rst0, 0);
    check("b2b_scoreboard_empty", exp_q.size(), 0);

    // Async reset during READ
    set_operands(0, 1, 1'b1);
    start_job();
    feed(NUM_PSUM, 1'b0);
    step();
    check("in_read", 32'(dp_read_en), 1);
    reset = 1'b0;
    #1;
    exp_q.delete();
    check("arst_busy", 32'(busy), 0);
    check("arst_pix_ready", 32'(pix_ready), 0);
    check("arst_dp_read_en", 32'(dp_read_en), 0);
    check("arst_res_valid", 32'(res_valid), 0);
    check("arst_res_data", 32'(res_data), 0);
    check("arst_res_index", 32'(res_index), 0);
    check("arst_dp_reset_n", 32'(dp_reset_n), 0);
    repeat (3) step();
    check("arst_dp_reset_n_held", 32'(dp_reset_n), 0);
    reset = 1'b1;
    step();

    // Recovery after reset
    run_job(1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/cnn1d_job_sequencer.md
# cnn1d_job_sequencer

Controller that sequences one 1-D convolution job through the single-layer CNN datapath (multiplier → 15-entry partial-sum register file → 3-input adder). It accepts (image, filter) operand pairs over a valid/ready stream, drives the datapath write and read enables for exactly one full counter revolution, and collects the five convolution results into a small output FIFO with backpressure. It also owns datapath reset on abort.

## Interface
- NUM_PSUM, 15, partial products per job (= register-file words)
- TAPS, 3, partial sums added per result
- NUM_RES, 5, results per job (NUM_PSUM / TAPS)
- DW, 4, operand width
- RW, 10, result width
- FIFO_DEPTH, 4, output FIFO entries

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-low reset
- job_start  in  1  single-cycle request to begin a job; ignored unless idle
- abort  in  1  terminate current job
- busy  out  1  high whenever state ≠ IDLE
- job_done  out  1  one-cycle pulse when job completes normally
- pix_valid  in  1  operand pair valid
- pix_ready  out  1  sequencer accepts operand pair
- pix_image  in  DW  image operand
- pix_filter  in  DW  filter operand
- dp_start  out  1  datapath Start (multiply and write enable)
- dp_image  out  DW  datapath Image
- dp_filter  out  DW  datapath Filter
- dp_read_en  out  1  datapath ReadEn
- dp_reset_n  out  1  datapath active-low reset
- dp_conv_result  in  RW  datapath ConvResult
- res_valid  out  1  FIFO head valid
- res_ready  in  1  consumer accepts head
- res_data  out  RW  convolution result
- res_index  out  3  result number 0..NUM_RES-1

## Operation
- States: IDLE, LOAD, READ, FINISH.
- IDLE: job_start=1 → LOAD; wr_cnt, rd_cnt cleared.
- LOAD: pix_ready=1; dp_start = pix_valid; dp_image/dp_filter = pix_image/pix_filter (combinational pass-through). Each handshake increments wr_cnt; the handshake making wr_cnt = NUM_PSUM → READ next cycle. pix_valid gaps stall without affecting the datapath.
- READ: dp_read_en = (rd_cnt < NUM_RES) && (fifo_cnt + inflight < FIFO_DEPTH). Each issue increments rd_cnt and enters a 2-stage valid/index pipe (register-file read stage, adder stage). Stage-2 valid pushes {rd_index, dp_conv_result} into the FIFO. rd_cnt = NUM_RES and pipe empty → FINISH.
- FINISH: waits for FIFO empty; then job_done pulse, → IDLE.
- Result k = psum[3k] + psum[3k+1] + psum[3k+2], psum[i] = image_i × filter_i; max 675, fits RW.
- Exactly NUM_PSUM dp_start and NUM_RES dp_read_en cycles per job, returning the datapath ring counters to their initial state; no datapath reset between normal jobs.
- abort (any state): → IDLE next edge; FIFO and pipe flushed; dp_reset_n low for exactly one cycle to re-home datapath counters. abort in IDLE also pulses dp_reset_n. abort wins over job_start in the same cycle.
- job_start while busy is ignored.
- FIFO push and pop in the same cycle keep fifo_cnt unchanged; a pop on empty is impossible (res_valid=0).

## Timing
- Reset values: state IDLE, busy 0, job_done 0, pix_ready 0, dp_start 0, dp_read_en 0, res_valid 0, res_data 0, res_index 0, counters and FIFO empty.
- dp_reset_n = reset AND NOT abort_pulse_q; low while reset is low.
- job_start at edge t → LOAD visible (pix_ready=1) in cycle t+1.
- Read latency: dp_read_en high in cycle c → dp_conv_result valid in cycle c+2 → FIFO push at end of c+2 → res_valid earliest in c+3.
- Minimum job with no stalls: 1 + 15 + 5 + 2 cycles to last push; job_done one cycle after last pop.
- Credit rule guarantees no FIFO overflow with res_ready held low indefinitely.

## Structure
- Shared package cnn1d_pkg: state enum, NUM_PSUM, TAPS, NUM_RES, RW, result-entry struct {index, data}.
- One sub-module: cnn1d_res_fifo (synchronous FIFO, depth FIFO_DEPTH, count output). FSM, counters, credit logic, and valid pipe in the top.

## Test plan
- Nominal: image_i = i, filter_i = 1, res_ready=1 → results 3, 12, 21, 30, 39 with indices 0–4; job_done once; 15 dp_start cycles, 5 dp_read_en cycles.
- Input gaps: pix_valid toggling 1/0 with image=15, filter=15 → dp_start only on valid cycles; all results 675.
- Backpressure: res_ready=0 throughout READ → dp_read_en stops after 4 issues; raising res_ready drains 4 results, issues the 5th; no loss or reordering.
- Abort mid-LOAD after 7 pairs → IDLE next cycle, dp_reset_n low one cycle, no job_done; a following nominal job yields correct results.
- Back-to-back jobs without datapath reset: second job (filter=2) → 6, 24, 42, 60, 78; job_start while busy ignored.
- Async reset asserted during READ → all outputs at reset values immediately; dp_reset_n low while reset is low.
